// File: rtl/axi4_sim_pkg.sv
// Shared encodings, FSM state types and burst address arithmetic for the
// AXI4 simulation slave.
package axi4_sim_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } rstate_t;

    // A WRAP burst is only legal for 2, 4, 8 or 16 beats; 2'b11 is reserved.
    function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
        if (burst == BURST_WRAP)
            return !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        return (burst == 2'b11);
    endfunction

    function automatic logic [1:0] burst_eff(input logic [1:0] burst, input logic [7:0] len);
        return burst_bad(burst, len) ? BURST_INCR : burst;
    endfunction

    // Word-address step; the caller truncates to its own word-address width.
    function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [7:0] len,
                                              input logic [1:0] burst);
        logic [63:0] mask;
        mask = {56'd0, len};
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (addr & ~mask) | ((addr + 64'd1) & mask);
            default:     return addr + 64'd1;
        endcase
    endfunction

endpackage

// File: rtl/axi4_sdp_ram.sv
// Simple dual-port RAM: byte-enabled write port and one-cycle registered read
// port. A same-cycle read of the word being written returns the old contents.
module axi4_sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096,
    localparam int AW        = $clog2(DEPTH),
    localparam int BW        = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BW-1:0]         wstrb,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BW; b++) begin
                if (wstrb[b])
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi4_burst_ram_slave.sv
// AXI4 burst RAM slave: independent write and read FSMs in front of a simple
// dual-port RAM, terminating FIXED/INCR/WRAP bursts of 1-256 beats.
module axi4_burst_ram_slave
    import axi4_sim_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 18,
    parameter int MEM_DEPTH_WORDS = 4096
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int OFF  = $clog2(DATA_WIDTH / 8);
    localparam int WAW  = ADDR_WIDTH - OFF;
    localparam int IDXW = $clog2(MEM_DEPTH_WORDS);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[OFF-1:0], ARADDR[OFF-1:0]};

    // Ready outputs stay low for the cycle that follows a sampled reset.
    logic rst_q;
    always_ff @(posedge ACLK) rst_q <= ARESET;

    wstate_t             wstate, wstate_n;
    logic [ID_WIDTH-1:0] wid_q;
    logic [WAW-1:0]      waddr_q;
    logic [7:0]          wlen_q, wcnt_q;
    logic [1:0]          wburst_q;
    logic                werr_q;
    logic                aw_hs, w_hs, w_last, w_oor, ram_we;

    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign w_last = (wcnt_q == wlen_q);
    assign w_oor  = (64'(waddr_q) >= 64'(MEM_DEPTH_WORDS));
    assign ram_we = w_hs && !w_oor && !ARESET;

    always_ff @(posedge ACLK) begin
        if (ARESET) wstate <= W_IDLE;
        else        wstate <= wstate_n;
    end

    always_comb begin
        wstate_n = wstate;
        case (wstate)
            W_IDLE:  if (aw_hs) wstate_n = W_DATA;
            W_DATA:  if (w_hs && w_last) wstate_n = W_RESP;
            W_RESP:  if (BREADY) wstate_n = W_IDLE;
            default: wstate_n = W_IDLE;
        endcase
    end

    always_comb begin
        AWREADY = (wstate == W_IDLE) && !rst_q;
        WREADY  = (wstate == W_DATA);
        BVALID  = (wstate == W_RESP);
        BID     = (wstate == W_RESP) ? wid_q : '0;
        BRESP   = ((wstate == W_RESP) && werr_q) ? RESP_SLVERR : RESP_OKAY;
    end

    // Beat count, not WLAST, terminates the burst; a WLAST disagreement only flags SLVERR.
    always_ff @(posedge ACLK) begin
        if (aw_hs) begin
            wid_q    <= AWID;
            waddr_q  <= AWADDR[ADDR_WIDTH-1:OFF];
            wlen_q   <= AWLEN;
            wburst_q <= burst_eff(AWBURST, AWLEN);
            wcnt_q   <= '0;
            werr_q   <= burst_bad(AWBURST, AWLEN);
        end else if (w_hs) begin
            wcnt_q  <= wcnt_q + 8'd1;
            waddr_q <= WAW'(next_addr(64'(waddr_q), wlen_q, wburst_q));
            if ((WLAST != w_last) || w_oor)
                werr_q <= 1'b1;
        end
    end

    rstate_t               rstate, rstate_n;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [WAW-1:0]        raddr_q;
    logic [7:0]            rlen_q, rcnt_q;
    logic [1:0]            rburst_q;
    logic                  rbad_q;
    logic                  ar_hs, r_hs, r_last, r_oor, ram_re;
    logic [DATA_WIDTH-1:0] rdata_p1;

    assign ar_hs  = ARVALID && ARREADY;
    assign r_hs   = RVALID && RREADY;
    assign r_last = (rcnt_q == rlen_q);
    assign r_oor  = (64'(raddr_q) >= 64'(MEM_DEPTH_WORDS));
    assign ram_re = (rstate == R_FETCH);

    always_ff @(posedge ACLK) begin
        if (ARESET) rstate <= R_IDLE;
        else        rstate <= rstate_n;
    end

    always_comb begin
        rstate_n = rstate;
        case (rstate)
            R_IDLE:  if (ar_hs) rstate_n = R_FETCH;
            R_FETCH: rstate_n = R_DATA;
            R_DATA:  if (r_hs) rstate_n = r_last ? R_IDLE : R_FETCH;
            default: rstate_n = R_IDLE;
        endcase
    end

    // rdata_p1 is only refreshed in R_FETCH, so the beat holds while stalled.
    always_comb begin
        ARREADY = (rstate == R_IDLE) && !rst_q;
        RVALID  = (rstate == R_DATA);
        RLAST   = (rstate == R_DATA) && r_last;
        RID     = (rstate == R_DATA) ? rid_q : '0;
        RDATA   = ((rstate == R_DATA) && !r_oor) ? rdata_p1 : '0;
        RRESP   = ((rstate == R_DATA) && (r_oor || rbad_q)) ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge ACLK) begin
        if (ar_hs) begin
            rid_q    <= ARID;
            raddr_q  <= ARADDR[ADDR_WIDTH-1:OFF];
            rlen_q   <= ARLEN;
            rburst_q <= burst_eff(ARBURST, ARLEN);
            rcnt_q   <= '0;
            rbad_q   <= burst_bad(ARBURST, ARLEN);
        end else if (r_hs) begin
            rcnt_q  <= rcnt_q + 8'd1;
            raddr_q <= WAW'(next_addr(64'(raddr_q), rlen_q, rburst_q));
        end
    end

    // Stage p0 -> p1: registered RAM read launched from R_FETCH.
    axi4_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH_WORDS)
    ) u_ram (
        .clk   (ACLK),
        .we    (ram_we),
        .waddr (waddr_q[IDXW-1:0]),
        .wdata (WDATA),
        .wstrb (WSTRB),
        .re    (ram_re),
        .raddr (raddr_q[IDXW-1:0]),
        .rdata (rdata_p1)
    );

endmodule

// File: tb/tb_axi4_burst_ram_slave.sv
// Randomized self-checking bench for axi4_burst_ram_slave against a
// word-array reference model of the AXI burst rules.
module tb_axi4_burst_ram_slave;

    localparam int IW    = 18;
    localparam int DEPTH = 4096;

    logic          ACLK;
    logic          ARESET;
    logic [IW-1:0] AWID, ARID, BID, RID;
    logic [15:0]   AWADDR, ARADDR;
    logic [7:0]    AWLEN, ARLEN;
    logic [1:0]    AWBURST, ARBURST, BRESP, RRESP;
    logic          AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [31:0]   WDATA, RDATA;
    logic [3:0]    WSTRB;

    axi4_burst_ram_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [31:0]   mdl     [DEPTH];
    logic [31:0]   wd      [256];
    logic [3:0]    ws      [256];
    logic [31:0]   rd_data [256];
    logic [1:0]    rd_resp [256];
    logic          rd_last [256];
    logic [IW-1:0] b_id;
    logic [1:0]    b_resp;
    logic [31:0]   exp3    [4] = '{32'hC, 32'hD, 32'hA, 32'hB};

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic bit burst_err(input logic [1:0] burst, input logic [7:0] len);
        if (burst == 2'b11) return 1'b1;
        if (burst == 2'b10) return !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
        return 1'b0;
    endfunction

    // Word touched by beat i, from the burst rules directly.
    function automatic int beat_word(input logic [15:0] addr, input logic [7:0] len,
                                     input logic [1:0] burst, input int i);
        int s, n;
        s = int'(addr) / 4;
        n = int'(len) + 1;
        if (burst == 2'b00) return s;
        if (burst == 2'b10 && !burst_err(burst, len)) return (s / n) * n + (s + i) % n;
        return (s + i) % 16384;
    endfunction

    task automatic fill_random(input int nb, input bit full);
        for (int i = 0; i < nb; i++) begin
            wd[i] = $urandom;
            ws[i] = full ? 4'hF : 4'($urandom_range(0, 15));
        end
    endtask

    task automatic aw_send(input logic [IW-1:0] id, input logic [15:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n;
        AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
        check("awready", 64'(AWREADY), 64'(1));
        @(negedge ACLK);
        AWVALID = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n;
        WDATA = d; WSTRB = s; WLAST = l; WVALID = 1'b1;
        n = 0;
        while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
        check("wready", 64'(WREADY), 64'(1));
        @(negedge ACLK);
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic model_write(input int word, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) mdl[word][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic axi_write(input logic [IW-1:0] id, input logic [15:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int bdelay, input int bad_beat);
        bit   err;
        int   n, word;
        logic lst;
        err = burst_err(burst, len);
        aw_send(id, addr, len, burst);
        for (int i = 0; i <= int'(len); i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge ACLK);
            lst = (i == int'(len)) ^ (i == bad_beat);
            if (lst != (i == int'(len))) err = 1'b1;
            word = beat_word(addr, len, burst, i);
            if (word >= DEPTH) err = 1'b1;
            else model_write(word, wd[i], ws[i]);
            w_beat(wd[i], ws[i], lst);
        end
        for (int c = 0; c < bdelay; c++) begin
            check("b_hold_valid", 64'(BVALID), 64'(1));
            check("b_hold_id", 64'(BID), 64'(id));
            check("b_hold_awready", 64'(AWREADY), 64'(0));
            @(negedge ACLK);
        end
        n = 0;
        while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
        check("bvalid", 64'(BVALID), 64'(1));
        b_id = BID; b_resp = BRESP;
        check("bid", 64'(BID), 64'(id));
        check("bresp", 64'(BRESP), err ? 64'(2) : 64'(0));
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        check("b_done", 64'(BVALID), 64'(0));
    endtask

    task automatic axi_read(input logic [IW-1:0] id, input logic [15:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        bit          err;
        int          n, word, stall;
        logic [31:0] ed;
        logic [1:0]  er;
        err = burst_err(burst, len);
        ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
        check("arready", 64'(ARREADY), 64'(1));
        @(negedge ACLK);
        ARVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
            check("r_latency", 64'(n), 64'(1));
            word = beat_word(addr, len, burst, i);
            ed = (word >= DEPTH) ? 32'h0 : mdl[word];
            er = (err || word >= DEPTH) ? 2'b10 : 2'b00;
            stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            for (int s = 0; s < stall; s++) begin
                @(negedge ACLK);
                check("r_stall_valid", 64'(RVALID), 64'(1));
                check("r_stall_data", 64'(RDATA), 64'(ed));
            end
            check("rdata", 64'(RDATA), 64'(ed));
            check("rresp", 64'(RRESP), 64'(er));
            check("rlast", 64'(RLAST), 64'(i == int'(len)));
            check("rid", 64'(RID), 64'(id));
            rd_data[i] = RDATA; rd_resp[i] = RRESP; rd_last[i] = RLAST;
            RREADY = 1'b1;
            @(negedge ACLK);
            RREADY = 1'b0;
        end
        check("r_after_last", 64'(RVALID), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        check("rst_awready", 64'(AWREADY), 64'(0));
        check("rst_arready", 64'(ARREADY), 64'(0));
        check("rst_bvalid", 64'(BVALID), 64'(0));
        check("rst_rvalid", 64'(RVALID), 64'(0));
        ARESET = 1'b0;
        @(negedge ACLK);
        check("rel_awready", 64'(AWREADY), 64'(1));
        check("rel_arready", 64'(ARREADY), 64'(1));

        // Single beat write and read back
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        axi_write(18'h2A5, 16'h0010, 8'd0, 2'b01, 0, -1);
        check("t1_bid", 64'(b_id), 64'(18'h2A5));
        check("t1_bresp", 64'(b_resp), 64'(0));
        axi_read(18'h013, 16'h0010, 8'd0, 2'b01);
        check("t1_rdata", 64'(rd_data[0]), 64'(32'hDEADBEEF));
        check("t1_rresp", 64'(rd_resp[0]), 64'(0));
        check("t1_rlast", 64'(rd_last[0]), 64'(1));

        // INCR burst
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        axi_write(18'h1, 16'h0100, 8'd3, 2'b01, 0, -1);
        axi_read(18'h2, 16'h0100, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) begin
            check("t2_data", 64'(rd_data[i]), 64'(i + 1));
            check("t2_last", 64'(rd_last[i]), 64'(i == 3));
        end

        // WRAP burst starting mid-block
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA + 32'(i); ws[i] = 4'hF; end
        axi_write(18'h3, 16'h0108, 8'd3, 2'b10, 0, -1);
        axi_read(18'h4, 16'h0100, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) check("t3_wrap", 64'(rd_data[i]), 64'(exp3[i]));

        // Byte strobes
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        axi_write(18'h5, 16'h0200, 8'd0, 2'b01, 0, -1);
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        axi_write(18'h5, 16'h0200, 8'd0, 2'b01, 0, -1);
        axi_read(18'h6, 16'h0200, 8'd0, 2'b01);
        check("t4_strobe", 64'(rd_data[0]), 64'(32'hFF22FF44));

        // Response back-pressure
        fill_random(2, 1'b1);
        axi_write(18'h3ABCD, 16'h0300, 8'd1, 2'b01, 10, -1);
        check("t5_bid", 64'(b_id), 64'(18'h3ABCD));

        // Illegal WRAP length and WLAST disagreement both report SLVERR
        fill_random(3, 1'b1);
        axi_write(18'h7, 16'h0400, 8'd2, 2'b10, 0, -1);
        check("t6_badwrap", 64'(b_resp), 64'(2));
        fill_random(4, 1'b1);
        axi_write(18'h8, 16'h0500, 8'd3, 2'b01, 0, 1);
        check("t6_wlast", 64'(b_resp), 64'(2));

        // Reset in the middle of a write burst
        aw_send(18'h9, 16'h0C00, 8'd3, 2'b01);
        wd[0] = 32'h0BADF00D; wd[1] = 32'hCAFE0001;
        model_write(32'h300, wd[0], 4'hF);
        model_write(32'h301, wd[1], 4'hF);
        w_beat(wd[0], 4'hF, 1'b0);
        w_beat(wd[1], 4'hF, 1'b0);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("mr_awready", 64'(AWREADY), 64'(0));
        check("mr_wready", 64'(WREADY), 64'(0));
        check("mr_bvalid", 64'(BVALID), 64'(0));
        check("mr_bid", 64'(BID), 64'(0));
        check("mr_bresp", 64'(BRESP), 64'(0));
        check("mr_arready", 64'(ARREADY), 64'(0));
        check("mr_rvalid", 64'(RVALID), 64'(0));
        check("mr_rdata", 64'(RDATA), 64'(0));
        check("mr_rid", 64'(RID), 64'(0));
        check("mr_rresp", 64'(RRESP), 64'(0));
        check("mr_rlast", 64'(RLAST), 64'(0));
        ARESET = 1'b0;
        @(negedge ACLK);
        check("mr_rel_awready", 64'(AWREADY), 64'(1));
        check("mr_rel_wready", 64'(WREADY), 64'(0));
        for (int c = 0; c < 3; c++) begin
            check("mr_no_b", 64'(BVALID), 64'(0));
            @(negedge ACLK);
        end
        axi_read(18'hA, 16'h0C00, 8'd1, 2'b01);

        // Out-of-range word
        axi_read(18'hB, 16'h4000, 8'd0, 2'b01);
        check("t7_oor_data", 64'(rd_data[0]), 64'(0));
        check("t7_oor_resp", 64'(rd_resp[0]), 64'(2));
        fill_random(1, 1'b1);
        axi_write(18'hC, 16'h4000, 8'd0, 2'b01, 0, -1);
        check("t7_oor_bresp", 64'(b_resp), 64'(2));

        // Preload the random windows so every read returns known data
        fill_random(64, 1'b1);
        axi_write(18'h0, 16'h0000, 8'd63, 2'b01, 0, -1);
        fill_random(16, 1'b1);
        axi_write(18'h0, 16'h3FC0, 8'd15, 2'b01, 0, -1);

        // Concurrent write and read on disjoint words
        fill_random(16, 1'b0);
        fork
            axi_write(18'h11, 16'h0000, 8'd15, 2'b01, 2, -1);
            axi_read(18'h22, 16'h0080, 8'd15, 2'b01);
        join

        for (int t = 0; t < 60; t++) begin
            logic [7:0]  l;
            logic [1:0]  bu;
            logic [15:0] a;
            int          sw;
            l  = 8'($urandom_range(0, 15));
            bu = 2'($urandom_range(0, 3));
            sw = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4080, 4095))
                                              : int'($urandom_range(0, 48));
            a  = 16'(sw * 4 + int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                fill_random(int'(l) + 1, 1'b0);
                axi_write(IW'($urandom), a, l, bu, int'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(l))) : -1);
            end else begin
                axi_read(IW'($urandom), a, l, bu);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_burst_ram_slave.md
Name: axi4_burst_ram_slave

Overview:
AXI4 slave memory that sits directly downstream of the system's AXI4 master BFM and terminates its read and write traffic. It stores data in an internal word-addressed array with one write port and one read port, so the read and write channels run concurrently. It supports FIXED, INCR and WRAP bursts of 1–256 beats with byte strobes. It is the default target for basic AXI simulation of the system.

Parameters:
ADDR_WIDTH, 16, byte address width of AWADDR/ARADDR
DATA_WIDTH, 32, data width; every beat is full width (size = log2(DATA_WIDTH/8))
ID_WIDTH, 18, transaction ID width, echoed on BID/RID
MEM_DEPTH_WORDS, 4096, storage depth in DATA_WIDTH words; must be a power of two

Ports:
ACLK  in  1  clock; all logic on the rising edge
ARESET  in  1  synchronous, active-high reset
AWID  in  ID_WIDTH  write ID
AWADDR  in  ADDR_WIDTH  write start byte address
AWLEN  in  8  beats minus 1
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte enables
WLAST  in  1  last write beat
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BID  out  ID_WIDTH  response ID (copy of AWID)
BRESP  out  2  00 OKAY, 10 SLVERR
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARID  in  ID_WIDTH  read ID
ARADDR  in  ADDR_WIDTH  read start byte address
ARLEN  in  8  beats minus 1
ARBURST  in  2  burst type, encoded as for AWBURST
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RID  out  ID_WIDTH  read ID (copy of ARID)
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  00 OKAY, 10 SLVERR
RLAST  out  1  last read beat
RVALID  out  1  read data valid
RREADY  in  1  read data ready

Behaviour:
- Reset (ARESET=1 sampled on ACLK): all outputs go to 0; both FSMs go to IDLE; memory contents are not cleared. AWREADY and ARREADY are 1 on the first cycle after reset is released. Reset asserted mid-burst abandons the burst; no B or R response is produced for it.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch ID, word address, LEN and BURST; clear the beat counter and the error flag; go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID&WREADY writes the enabled bytes at the current word and advances the address.
  - After beat LEN+1 go to W_RESP. This count, not WLAST, ends the burst.
  - Set the error flag if WLAST disagrees with the count on any beat.
  - W_RESP: BVALID=1 and BID=latched ID. BRESP=10 if the error flag is set, else 00. BID/BRESP are held stable until BREADY, then go to W_IDLE.
  - Exactly one write is outstanding at a time; AWREADY=0 outside W_IDLE.
- Read FSM R_IDLE -> R_FETCH -> R_DATA:
  - R_IDLE: ARREADY=1. On handshake, latch ID, address, LEN and BURST; go to R_FETCH.
  - R_FETCH: one-cycle registered RAM read; go to R_DATA.
  - R_DATA: RVALID=1, RLAST=1 on beat LEN+1 only. RDATA, RID, RRESP and RLAST are held stable while RVALID&!RREADY.
  - On handshake: if last, go to R_IDLE; else advance the address and go to R_FETCH.
  - Throughput: one beat per 2 cycles. First RVALID appears 2 cycles after the AR handshake.
- Address generation, in word units (word = byte_addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]):
  - FIXED: address constant across the burst.
  - INCR: +1 per beat, wrapping modulo 2^(word address width).
  - WRAP: mask = LEN; next = (a & ~mask) | ((a+1) & mask). LEN must be 1, 3, 7 or 15; any other LEN, or BURST=11, is treated as INCR and returns SLVERR.
  - Low byte-address bits are ignored; 4 KB boundary crossing is not checked.
- Out of range (word >= MEM_DEPTH_WORDS):
  - Write beat: dropped; sets the error flag.
  - Read beat: RDATA=0, RRESP=10 for that beat.
  - Memory indexing uses word mod MEM_DEPTH_WORDS only for in-range addresses.
- Same-cycle write and read to the same word: the read returns the old data.

Decomposition:
- Package axi4_sim_pkg holds: burst encodings BURST_FIXED/INCR/WRAP; RESP_OKAY/RESP_SLVERR; FSM state enums; function next_addr(addr, len, burst).
- One sub-module, axi4_sdp_ram: simple dual-port RAM with byte-enable write and one-cycle registered read.

Test Plan:
- Single write to 0x0010, AWID=0x2A5, data 0xDEADBEEF, WSTRB=1111, then single read of 0x0010 -> BID=0x2A5, BRESP=00; RDATA=0xDEADBEEF, RRESP=00, RLAST=1.
- INCR write, AWLEN=3, at 0x0100, data 1,2,3,4; INCR read-back -> 4 beats 1,2,3,4 with RLAST only on beat 4.
- WRAP write, AWLEN=3, start 0x0108, data A,B,C,D; INCR read of 0x0100, len 3 -> C,D,A,B.
- Preload 0xFFFFFFFF, then write 0x11223344 with WSTRB=0101 -> read returns 0xFF22FF44.
- BREADY held low 10 cycles -> BVALID and BID held stable, AWREADY=0 throughout. Random RREADY gaps -> RDATA stable while stalled, no beat lost or duplicated.
- ARESET pulse after 2 of 4 write beats -> next cycle all outputs 0, no B response, AWREADY=1 after release. Read of a word >= MEM_DEPTH_WORDS -> RDATA=0, RRESP=10.
